credit_tx: RTL and testbench
============================

# credit_tx

Transmit-side credit controller that pushes a valid/ready producer stream into a remote, non-backpressuring FIFO of known depth. It holds a credit counter initialised to the remote FIFO depth, spends one credit per push, and regains one per remote pop (`credit_i`), so the remote FIFO can never overflow. It sits in front of any `fifo_v2` instance reached over a link with no `full_o` feedback path.

## Interface
- `DATA_WIDTH`, 32: payload width.
- `DEPTH`, 8: remote FIFO depth and initial credit count; legal range 1..2**16.
- `LOW_TH`, 1: `low_credit_o` asserts when credits ≤ `LOW_TH`.
- `CNT_WIDTH`, `$clog2(DEPTH+1)`: derived width; not to be overridden.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: synchronous flush; remote FIFO is flushed in the same cycle.
- `valid_i` in 1: producer data valid.
- `ready_o` out 1: a credit is available and the beat is accepted.
- `data_i` in `DATA_WIDTH`: producer payload.
- `valid_o` out 1: push strobe to the remote FIFO (`push_i`).
- `data_o` out `DATA_WIDTH`: payload to the remote FIFO.
- `credit_i` in 1: one-cycle pulse per remote pop; at most one per cycle.
- `credits_o` out `CNT_WIDTH`: current credit count.
- `low_credit_o` out 1: credits ≤ `LOW_TH`.
- `err_o` out 1: sticky credit-overflow error.

## Operation
- Handshake: `send = valid_i & ready_o`; `ready_o = (credits != 0) & ~flush_i`. `ready_o` never depends on `valid_i`. `valid_i`/`data_i` must stay stable until accepted.
- Counter next value: `credits - send + credit_i`, computed in `CNT_WIDTH+1` bits.
- Send and credit in the same cycle: count unchanged.
- Credit at `credits == DEPTH` with no send (overflow): count saturates at `DEPTH` and `err_o` sets.
- `err_o` clears only on reset or `flush_i`.
- `credits == 0`: `ready_o` = 0. A `credit_i` in that cycle raises the count to 1 on the next edge; there is no same-cycle bypass.
- Flush: count is reloaded to `DEPTH`, `err_o` clears, `credit_i` is ignored, no send occurs, and any pending output beat is dropped.
- `low_credit_o = (credits <= LOW_TH)`, combinational from the counter register.
- Reset values: `credits_o` = `DEPTH`; `valid_o` = 0; `data_o` = 0; `err_o` = 0; `ready_o` = 1; `low_credit_o` = (`DEPTH <= LOW_TH`).
- Reset asserted mid-transfer: any in-flight beat is discarded.

## Timing
- A send or credit in cycle t is reflected in `credits_o` and `ready_o` at t+1.
- Output latency is set by the macro below: 0 cycles (combinational) or 1 cycle (registered).
- Sustained throughput is 1 beat per cycle when `credit_i` returns at the consumption rate. With a round-trip credit delay R, full rate needs `DEPTH` > R.

## Configuration
- `CREDIT_TX_OUT_REG_EN` defined: `valid_o`/`data_o` come from a register loaded on `send`. `valid_o` is high for exactly the cycle after acceptance. `data_o` holds its last value when `valid_o` = 0.
- `CREDIT_TX_OUT_REG_EN` undefined: `valid_o = send` and `data_o = data_i`, both combinational.
- Credit accounting is identical in both modes.

## Structure
- Package `credit_pkg`:
  - function `credit_cnt_width(depth)`;
  - the saturating update function shared with a future `credit_rx`.
- Sub-module `credit_counter`: holds the counter, saturation, `err_o` and flush logic, with parameters `DEPTH` and `LOW_TH`.
- Top level: handshake logic plus the optional output register.

## Test plan
- Reset with `DEPTH`=8, `LOW_TH`=1 -> `credits_o`=8, `ready_o`=1, `valid_o`=0, `err_o`=0, `low_credit_o`=0.
- Hold `valid_i` for 10 cycles, no credits -> exactly 8 beats accepted, `ready_o`=0 from cycle 8, `low_credit_o` high at credits 1 and 0. With the macro: `valid_o` pulses cycles 1..8 with matching `data_o`.
- At credits 0, pulse `credit_i` once -> `credits_o`=1 next cycle, one beat accepted, count back to 0.
- Continuous `valid_i` and `credit_i` at credits 3 -> count stays at 3 and one beat per cycle is delivered.
- At credits 8, pulse `credit_i` -> `credits_o` stays 8, `err_o`=1 and remains set. A following `flush_i` -> `err_o`=0.
- At credits 2, `flush_i` together with `valid_i` and `credit_i` -> no beat accepted, `credits_o`=8 next cycle. Deassert `rst_ni` mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/credit_pkg.sv
// Shared credit-flow types and helpers for the credit_tx/credit_rx pair.
// The saturating update is written once here so both ends account credits identically.
package credit_pkg;

    localparam int CNT_MAX_W = 17;

    typedef logic [CNT_MAX_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t cnt;
        logic ovf;
    } credit_upd_t;

    function automatic int credit_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One extra bit of headroom so an increment at full count is visible as overflow
    function automatic credit_upd_t credit_update(
        input cnt_t cnt,
        input logic dec,
        input logic inc,
        input cnt_t depth
    );
        logic [CNT_MAX_W:0] nxt;
        credit_upd_t        r;
        nxt = {1'b0, cnt}
            - {{CNT_MAX_W{1'b0}}, dec}
            + {{CNT_MAX_W{1'b0}}, inc};
        if (nxt > {1'b0, depth}) begin
            r.cnt = depth;
            r.ovf = 1'b1;
        end else begin
            r.cnt = nxt[CNT_MAX_W-1:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit counter: saturating at DEPTH, sticky overflow error, flush reload.
// Low-credit flag is decoded straight from the counter register.
module credit_counter
    import credit_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned LOW_TH = 1,
    localparam int CNT_WIDTH = credit_cnt_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 dec_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] credits_o,
    output logic                 low_credit_o,
    output logic                 err_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 err_q;
    credit_upd_t          upd;

    always_comb begin
        upd = credit_update(cnt_t'(cnt_q), dec_i, inc_i, cnt_t'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= CNT_WIDTH'(DEPTH);
            err_q <= 1'b0;
        end else if (flush_i) begin
            cnt_q <= CNT_WIDTH'(DEPTH);
            err_q <= 1'b0;
        end else begin
            cnt_q <= upd.cnt[CNT_WIDTH-1:0];
            if (upd.ovf) begin
                err_q <= 1'b1;
            end
        end
    end

    assign credits_o    = cnt_q;
    assign err_o        = err_q;
    assign low_credit_o = ({{(32-CNT_WIDTH){1'b0}}, cnt_q} <= LOW_TH);

endmodule

// File: rtl/credit_tx.sv
// Transmit-side credit controller feeding a remote FIFO without full feedback.
// Define CREDIT_TX_OUT_REG_EN to register valid_o/data_o (1-cycle latency).
module credit_tx
    import credit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LOW_TH     = 1,
    parameter int          CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic [CNT_WIDTH-1:0]  credits_o,
    output logic                  low_credit_o,
    output logic                  err_o
);

    logic send;

    assign ready_o = (credits_o != '0) & ~flush_i;
    assign send    = valid_i & ready_o;

    credit_counter #(
        .DEPTH  (DEPTH),
        .LOW_TH (LOW_TH)
    ) u_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .dec_i        (send),
        .inc_i        (credit_i),
        .credits_o    (credits_o),
        .low_credit_o (low_credit_o),
        .err_o        (err_o)
    );

`ifdef CREDIT_TX_OUT_REG_EN
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= send;
            if (send) begin
                data_q <= data_i;
            end
        end
    end

    // A beat still in the output register is dropped with the remote flush
    assign valid_o = valid_q & ~flush_i;
    assign data_o  = data_q;
`else
    assign valid_o = send;
    assign data_o  = data_i;
`endif

endmodule

// File: tb/tb_credit_tx.sv
// Scoreboard bench for credit_tx: credit-count model plus queue of expected beats.
// Works with or without CREDIT_TX_OUT_REG_EN defined.
module tb_credit_tx;

    localparam int DEPTH  = 8;
    localparam int LOW_TH = 1;
`ifdef CREDIT_TX_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        credit_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic [3:0]  credits_o;
    logic        low_credit_o;
    logic        err_o;

    credit_tx #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .LOW_TH     (LOW_TH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .credits_o    (credits_o),
        .low_credit_o (low_credit_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int obs   = 0;
    int mcred = DEPTH;
    bit merr  = 1'b0;
    bit last_acc = 1'b0;

    typedef struct {
        logic [31:0] d;
        int          due;
    } beat_t;
    beat_t exp_q[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Reference: credits are a bounded integer pool of size DEPTH
    always @(posedge clk or negedge rst_ni) begin
        int n;
        if (!rst_ni) begin
            mcred = DEPTH;
            merr  = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (flush_i) begin
                mcred = DEPTH;
                merr  = 1'b0;
            end else begin
                n = mcred;
                if (valid_i && mcred > 0) n = n - 1;
                if (credit_i) n = n + 1;
                if (n > DEPTH) begin
                    n    = DEPTH;
                    merr = 1'b1;
                end
                mcred = n;
            end
        end
    end

    always @(negedge clk) begin
        logic        exp_v;
        logic [31:0] exp_d;
        if (rst_ni) begin
            exp_v = 1'b0;
            exp_d = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_d = exp_q[0].d;
                exp_q.pop_front();
                exp_v = !(LAT == 1 && flush_i);
            end
            chk("valid_o", 32'(valid_o), 32'(exp_v));
            if (valid_o) obs++;
            if (exp_v && valid_o) chk("data_o", data_o, exp_d);
            chk("credits_o", 32'(credits_o), 32'(mcred));
            chk("ready_o", 32'(ready_o), 32'(mcred != 0 && !flush_i));
            chk("low_credit_o", 32'(low_credit_o), 32'(mcred <= LOW_TH));
            chk("err_o", 32'(err_o), 32'(merr));
        end
    end

    task automatic step(input bit v, input logic [31:0] d, input bit c, input bit f);
        @(posedge clk);
        #1;
        valid_i  = v;
        data_i   = d;
        credit_i = c;
        flush_i  = f;
        last_acc = v && mcred != 0 && !f;
        if (last_acc) exp_q.push_back('{d: d, due: cyc + LAT});
    endtask

    task automatic idle_settle();
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_credits"}, 32'(credits_o), 32'(DEPTH));
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_low"}, 32'(low_credit_o), 32'd0);
`ifdef CREDIT_TX_OUT_REG_EN
        chk({tag, "_data"}, data_o, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int          base;
        logic [31:0] cur;
        bit          v;
        logic [31:0] d;
        cur = 32'h100;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        #2;
        rst_ni = 1'b1;

        idle_settle();
        base = obs;
        repeat (10) begin
            step(1'b1, cur, 1'b0, 1'b0);
            if (last_acc) cur++;
        end
        idle_settle();
        chk("burst_beats", 32'(obs - base), 32'd8);
        chk("burst_empty", 32'(credits_o), 32'd0);

        base = obs;
        step(1'b1, cur, 1'b1, 1'b0);
        if (last_acc) cur++;
        repeat (3) begin
            step(1'b1, cur, 1'b0, 1'b0);
            if (last_acc) cur++;
        end
        idle_settle();
        chk("credit_at_zero_beats", 32'(obs - base), 32'd1);
        chk("credit_at_zero_cnt", 32'(credits_o), 32'd0);

        step(1'b0, '0, 1'b0, 1'b1);
        repeat (5) begin
            step(1'b1, cur, 1'b0, 1'b0);
            if (last_acc) cur++;
        end
        idle_settle();
        base = obs;
        repeat (6) begin
            step(1'b1, cur, 1'b1, 1'b0);
            if (last_acc) cur++;
        end
        idle_settle();
        chk("steady_beats", 32'(obs - base), 32'd6);
        chk("steady_cnt", 32'(credits_o), 32'd3);

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle_settle();
        idle_settle();
        chk("err_sticky", 32'(err_o), 32'd1);
        chk("ovf_cnt", 32'(credits_o), 32'd8);
        step(1'b0, '0, 1'b0, 1'b1);
        idle_settle();
        chk("err_cleared", 32'(err_o), 32'd0);

        repeat (6) begin
            step(1'b1, cur, 1'b0, 1'b0);
            if (last_acc) cur++;
        end
        idle_settle();
        chk("pre_flush_cnt", 32'(credits_o), 32'd2);
        base = obs;
        step(1'b1, cur, 1'b1, 1'b1);
        idle_settle();
        chk("flush_no_beat", 32'(obs - base), 32'd0);
        chk("flush_cnt", 32'(credits_o), 32'd8);

        v = 1'b0;
        d = '0;
        last_acc = 1'b0;
        repeat (400) begin
            if (!v || last_acc) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
            end
            step(v, d, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
        end
        idle_settle();

        step(1'b0, '0, 1'b0, 1'b1);
        repeat (3) begin
            step(1'b1, cur, 1'b0, 1'b0);
            if (last_acc) cur++;
        end
        #2;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        #2;
        rst_ni = 1'b1;
        idle_settle();
        idle_settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
